delay_line_meter: RTL and testbench
===================================

DELAY_LINE_METER -- requirements
Module: delay_line_meter

Interface
REQ-001 Parameter FLUSH_CYCLES, 96, number of cycles tx_data is driven to zero before each probe; range 1..255.
REQ-002 Parameter MAX_WAIT, 255, timeout limit in cycles counted from the probe cycle; range 1..255.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin a measurement; sampled only in IDLE.
REQ-006 probe_pattern  input  8  marker byte launched into the line under test; sampled at start acceptance.
REQ-007 rx_data  input  8  far-end output of the delay line under test.
REQ-008 tx_data  output  8  registered drive into the delay line under test.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when a result is valid.
REQ-011 timeout  output  1  result flag: no match within MAX_WAIT; held with the result.
REQ-012 delay_count  output  8  measured delay in clock cycles; held until the next accepted start.

Function
REQ-013 The FSM SHALL have the states IDLE, FLUSH, PROBE, WAIT and DONE.
REQ-014 IDLE with start=1 SHALL latch probe_pattern, clear timeout and delay_count, and go to FLUSH.
REQ-015 IDLE with start=1 and probe_pattern=0 SHALL go directly to DONE with timeout=1 and delay_count=8'hFF.
REQ-016 FLUSH SHALL drive tx_data=0 for exactly FLUSH_CYCLES cycles, then go to PROBE.
REQ-017 PROBE SHALL last one cycle with tx_data=latched pattern and cycle counter=0, then go to WAIT; tx_data SHALL return to 0 in WAIT.
REQ-018 In PROBE and WAIT, rx_data equal to the latched pattern SHALL capture the counter into delay_count and go to DONE; the counter increments by 1 per WAIT cycle.
REQ-019 Delay definition: a line that shows tx_data on rx_data D cycles later SHALL yield delay_count=D, with D=0 for combinational loopback.
REQ-020 A counter reaching MAX_WAIT without a match SHALL set timeout=1 and delay_count=8'hFF and go to DONE.
REQ-021 If a match and MAX_WAIT occur in the same cycle, the match SHALL win (timeout=0).
REQ-022 DONE SHALL assert done for one cycle and return to IDLE; a start in the DONE cycle SHALL be ignored.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 The counter SHALL saturate and never wrap.

Reset
REQ-025 Asserting reset_n at any time, including mid-measurement, SHALL force IDLE, tx_data=0, busy=0, done=0, timeout=0, delay_count=0, and clear the latched pattern and counter.
REQ-026 The first accepted start SHALL be on the first rising edge after reset_n deasserts.

Configuration
REQ-027 Macro DELAY_LINE_METER_AVG_EN defined: one accepted start SHALL run four consecutive FLUSH-PROBE-WAIT passes, accumulate in a 10-bit sum, and report delay_count=floor(sum/4).
REQ-028 With DELAY_LINE_METER_AVG_EN, a timeout in any pass SHALL abort the remaining passes and report timeout=1 and delay_count=8'hFF.
REQ-029 Macro undefined: one pass per start, with no accumulator logic synthesised.

Structure
REQ-030 Package delay_line_meter_pkg SHALL hold the FSM state typedef, COUNT_W=8, TIMEOUT_CODE=8'hFF and AVG_PASSES=4.
REQ-031 The FSM, counter and pass logic SHALL be implemented in delay_line_meter alone, with no sub-module.

Verification
REQ-032 Loopback through a 30-stage 8-bit register chain, pattern 8'hA5, start pulse -> done after 96+1+30 cycles, delay_count=30, timeout=0.
REQ-033 Loopback through a 90-stage chain, pattern 8'h3C -> delay_count=90; with MAX_WAIT=60 -> timeout=1, delay_count=8'hFF, done at 60 cycles after PROBE.
REQ-034 rx_data tied to tx_data, pattern 8'h01 -> delay_count=0; pattern 8'h00 -> done on the next cycle, timeout=1.
REQ-035 reset_n pulsed low in mid-WAIT of a 45-stage measurement -> all outputs 0 in the same cycle; a new start then measures 45 correctly.
REQ-036 start held high through a 60-stage measurement -> exactly one done per IDLE entry; start in the DONE cycle is ignored; with AVG_EN, a 60-stage line yields 60.

Source files
------------

// File: rtl/delay_line_meter_pkg.sv
// delay_line_meter_pkg: shared FSM state type and constants for the delay line meter.
package delay_line_meter_pkg;
    typedef enum logic [2:0] {IDLE, FLUSH, PROBE, WAIT, DONE} state_t;
    localparam int COUNT_W = 8;
    localparam logic [COUNT_W-1:0] TIMEOUT_CODE = 8'hFF;
    localparam int AVG_PASSES = 4;
endpackage

// File: rtl/delay_line_meter_if.sv
// delay_line_meter_if: measurement request/result bus plus the drive and return of the line under test.
interface delay_line_meter_if;
    logic start;
    logic [delay_line_meter_pkg::COUNT_W-1:0] probe_pattern;
    logic [delay_line_meter_pkg::COUNT_W-1:0] rx_data;
    logic [delay_line_meter_pkg::COUNT_W-1:0] tx_data;
    logic busy;
    logic done;
    logic timeout;
    logic [delay_line_meter_pkg::COUNT_W-1:0] delay_count;
    modport master (output start, probe_pattern, rx_data, input tx_data, busy, done, timeout, delay_count);
    modport slave (input start, probe_pattern, rx_data, output tx_data, busy, done, timeout, delay_count);
endinterface

// File: rtl/delay_line_meter.sv
// delay_line_meter: flushes a delay line, launches a marker byte and counts cycles until it returns.
// Define DELAY_LINE_METER_AVG_EN to average AVG_PASSES back-to-back passes per start.
module delay_line_meter
    import delay_line_meter_pkg::*;
#(
    parameter int FLUSH_CYCLES = 96,
    parameter int MAX_WAIT = 255
) (
    input logic clock,
    input logic reset_n,
    delay_line_meter_if.slave bus
);
    localparam logic [COUNT_W-1:0] FLUSH_LAST = COUNT_W'(FLUSH_CYCLES - 1);
    localparam logic [COUNT_W-1:0] WAIT_LAST = COUNT_W'(MAX_WAIT);
    state_t state_q, state_d;
    logic [COUNT_W-1:0] pattern_q, pattern_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [COUNT_W-1:0] tx_q, tx_d;
    logic [COUNT_W-1:0] delay_q, delay_d;
    logic timeout_q, timeout_d;
    logic match;
`ifdef DELAY_LINE_METER_AVG_EN
    logic [1:0] pass_q, pass_d;
    logic [9:0] sum_q, sum_d, sum_next;
    assign sum_next = sum_q + {2'b00, cnt_q};
`endif
    assign match = bus.rx_data == pattern_q;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pattern_q <= '0;
            cnt_q <= '0;
            tx_q <= '0;
            delay_q <= '0;
            timeout_q <= 1'b0;
`ifdef DELAY_LINE_METER_AVG_EN
            pass_q <= '0;
            sum_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            pattern_q <= pattern_d;
            cnt_q <= cnt_d;
            tx_q <= tx_d;
            delay_q <= delay_d;
            timeout_q <= timeout_d;
`ifdef DELAY_LINE_METER_AVG_EN
            pass_q <= pass_d;
            sum_q <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pattern_d = pattern_q;
        cnt_d = cnt_q;
        delay_d = delay_q;
        timeout_d = timeout_q;
`ifdef DELAY_LINE_METER_AVG_EN
        pass_d = pass_q;
        sum_d = sum_q;
`endif
        unique case (state_q)
            IDLE: if (bus.start) begin
                pattern_d = bus.probe_pattern;
                cnt_d = '0;
                timeout_d = bus.probe_pattern == '0;
                delay_d = (bus.probe_pattern == '0) ? TIMEOUT_CODE : '0;
                state_d = (bus.probe_pattern == '0) ? DONE : FLUSH;
`ifdef DELAY_LINE_METER_AVG_EN
                pass_d = '0;
                sum_d = '0;
`endif
            end
            FLUSH: begin
                state_d = (cnt_q == FLUSH_LAST) ? PROBE : FLUSH;
                cnt_d = (cnt_q == FLUSH_LAST) ? '0 : cnt_inc;
            end
            PROBE, WAIT: if (match) begin
`ifdef DELAY_LINE_METER_AVG_EN
                sum_d = sum_next;
                cnt_d = '0;
                pass_d = pass_q + 1'b1;
                state_d = (pass_q == 2'(AVG_PASSES - 1)) ? DONE : FLUSH;
                delay_d = (pass_q == 2'(AVG_PASSES - 1)) ? COUNT_W'(sum_next / 10'(AVG_PASSES)) : delay_q;
`else
                state_d = DONE;
                delay_d = cnt_q;
`endif
            end else if (cnt_q == WAIT_LAST) begin
                state_d = DONE;
                timeout_d = 1'b1;
                delay_d = TIMEOUT_CODE;
            end else begin
                state_d = WAIT;
                cnt_d = cnt_inc;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        tx_d = (state_d == PROBE) ? pattern_d : '0;
    end

    always_comb begin
        bus.busy = state_q != IDLE;
        bus.done = state_q == DONE;
    end

    assign bus.tx_data = tx_q;
    assign bus.delay_count = delay_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_delay_line_meter.sv
// tb_delay_line_meter: directed bench with register-chain loopbacks and a result scoreboard.
module tb_delay_line_meter;
    localparam int F = 96;
`ifdef DELAY_LINE_METER_AVG_EN
    localparam int PASSES = 4;
`else
    localparam int PASSES = 1;
`endif
    localparam int LIMIT = 2000;

    typedef struct {
        logic [7:0] dc;
        logic to;
        int lat;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int depth = 0;
    bit sel = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    exp_t sb[$];
    logic [7:0] ch_a [0:127];
    logic [7:0] ch_b [0:127];

    delay_line_meter_if a ();
    delay_line_meter_if b ();

    delay_line_meter dut_a (.clock(clock), .reset_n(reset_n), .bus(a.slave));
    delay_line_meter #(.FLUSH_CYCLES(96), .MAX_WAIT(60)) dut_b (.clock(clock), .reset_n(reset_n), .bus(b.slave));

    always #5 clock = ~clock;

    always_ff @(posedge clock) begin
        ch_a[0] <= a.tx_data;
        ch_b[0] <= b.tx_data;
        for (int i = 1; i < 128; i++) begin
            ch_a[i] <= ch_a[i-1];
            ch_b[i] <= ch_b[i-1];
        end
    end

    assign a.rx_data = (depth == 0) ? a.tx_data : ch_a[depth-1];
    assign b.rx_data = (depth == 0) ? b.tx_data : ch_b[depth-1];

    function automatic int lat_of(input int d);
        return PASSES * (F + 1 + d);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        exp_t e;
        cyc = 0;
        while (!(sel ? b.done : a.done) && cyc < LIMIT) begin
            step();
            cyc++;
        end
        if (cyc >= LIMIT) begin
            check({tag, "_done_seen"}, 32'd0, 32'd1);
        end else if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_delay"}, sel ? b.delay_count : a.delay_count, e.dc);
            check({tag, "_timeout"}, sel ? b.timeout : a.timeout, e.to);
            check({tag, "_latency"}, cyc, e.lat);
        end
    endtask

    task automatic measure(input string tag, input bit s, input int d, input logic [7:0] pat,
                           input logic [7:0] dc, input logic to, input int lat);
        sel = s;
        depth = d;
        sb.push_back('{dc, to, lat});
        @(negedge clock);
        if (s) begin b.start = 1'b1; b.probe_pattern = pat; end
        else begin a.start = 1'b1; a.probe_pattern = pat; end
        step();
        a.start = 1'b0;
        b.start = 1'b0;
        wait_done(tag);
        step();
        check({tag, "_done_pulse"}, s ? b.done : a.done, 1'b0);
        check({tag, "_idle"}, s ? b.busy : a.busy, 1'b0);
    endtask

    initial begin
        a.start = 1'b0;
        a.probe_pattern = '0;
        b.start = 1'b0;
        b.probe_pattern = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_tx", a.tx_data, 8'h00);
        check("rst_busy", a.busy, 1'b0);
        check("rst_done", a.done, 1'b0);
        check("rst_timeout", a.timeout, 1'b0);
        check("rst_delay", a.delay_count, 8'h00);
        @(negedge clock);
        reset_n = 1'b1;

        measure("chain30", 0, 30, 8'hA5, 8'd30, 1'b0, lat_of(30));
        measure("chain90", 0, 90, 8'h3C, 8'd90, 1'b0, lat_of(90));
        measure("chain90_maxwait60", 1, 90, 8'h3C, 8'hFF, 1'b1, F + 1 + 60);
        measure("loopback01", 0, 0, 8'h01, 8'd0, 1'b0, lat_of(0));
        measure("loopback00", 0, 0, 8'h00, 8'hFF, 1'b1, 0);

        sel = 1'b0;
        depth = 45;
        @(negedge clock);
        a.start = 1'b1;
        a.probe_pattern = 8'h5A;
        step();
        a.start = 1'b0;
        repeat (F + 1 + 20) step();
        check("mid_wait_busy", a.busy, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_tx", a.tx_data, 8'h00);
        check("async_rst_busy", a.busy, 1'b0);
        check("async_rst_done", a.done, 1'b0);
        check("async_rst_timeout", a.timeout, 1'b0);
        check("async_rst_delay", a.delay_count, 8'h00);
        @(negedge clock);
        reset_n = 1'b1;
        measure("chain45_after_rst", 0, 45, 8'h5A, 8'd45, 1'b0, lat_of(45));

        depth = 60;
        sb.push_back('{8'd60, 1'b0, lat_of(60)});
        sb.push_back('{8'd60, 1'b0, lat_of(60)});
        @(negedge clock);
        a.start = 1'b1;
        a.probe_pattern = 8'hC3;
        step();
        wait_done("held1");
        step();
        check("held_done_pulse", a.done, 1'b0);
        check("held_ignored_in_done", a.busy, 1'b0);
        step();
        check("held_reaccept", a.busy, 1'b1);
        wait_done("held2");
        a.start = 1'b0;
        step();
        check("held_final_idle", a.busy, 1'b0);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
